alu_sequencer: RTL and testbench

//   Control-side master of the 8-bit ALU: fetches instructions from a synchronous ROM, decodes them,

---
 rtl/seq_pkg.sv | 39 +++
 rtl/seq_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the ALU sequencer: instruction classes, ALU op codes,
// FSM states and instruction field offsets.
package seq_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_MOV  = 2'b01,
        CLS_JMP  = 2'b10,
        CLS_HALT = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Control field offsets, counted from the top of the immediate field.
    localparam int unsigned CLS_LSB  = 6;
    localparam int unsigned OP_LSB   = 3;
    localparam int unsigned DST_BIT  = 2;
    localparam int unsigned BSEL_BIT = 1;
    localparam int unsigned JZ_BIT   = 0;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: splits a latched instruction word into
// class, ALU select, destination, operand-b select, jump condition and immediate.
module seq_decode
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W+7:0] instr_i,
    output cls_e              cls_o,
    output logic [2:0]        alu_s_o,
    output logic              dst_o,
    output logic              bsel_o,
    output logic              jz_o,
    output logic [DATA_W-1:0] imm_o
);

    logic [2:0] op;

    assign cls_o  = cls_e'(instr_i[DATA_W+CLS_LSB +: 2]);
    assign op     = instr_i[DATA_W+OP_LSB +: 3];
    assign dst_o  = instr_i[DATA_W+DST_BIT];
    assign bsel_o = instr_i[DATA_W+BSEL_BIT];
    assign jz_o   = instr_i[DATA_W+JZ_BIT];
    assign imm_o  = instr_i[DATA_W-1:0];

    // Only ALU-class instructions reach the ALU with their own op; others present ADD.
    assign alu_s_o = (cls_o == CLS_ALU) ? op : OP_ADD;

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: fetch from a 1-cycle-latency ROM,
// decode, drive the ALU, and write results back into working registers A/B.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned      DATA_W   = 8,
    parameter int unsigned      ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W+7:0] rom_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_s,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              flag_z,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   reg_a_q, reg_a_d;
    logic [DATA_W-1:0]   reg_b_q, reg_b_d;
    logic                flag_z_q, flag_z_d;
    logic [DATA_W+7:0]   instr_q, instr_d;

    cls_e                dec_cls;
    logic [2:0]          dec_alu_s;
    logic                dec_dst;
    logic                dec_bsel;
    logic                dec_jz;
    logic [DATA_W-1:0]   dec_imm;
    logic [ADDR_W-1:0]   pc_inc;
    logic [DATA_W-1:0]   wb_val;

    seq_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .instr_i (instr_q),
        .cls_o   (dec_cls),
        .alu_s_o (dec_alu_s),
        .dst_o   (dec_dst),
        .bsel_o  (dec_bsel),
        .jz_o    (dec_jz),
        .imm_o   (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            flag_z_q <= 1'b0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            flag_z_q <= flag_z_d;
            instr_q  <= instr_d;
        end
    end

    assign pc_inc = pc_q + ADDR_W'(1);
    assign wb_val = (dec_cls == CLS_MOV) ? dec_imm : alu_out;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        flag_z_d = flag_z_q;
        instr_d  = instr_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                instr_d = rom_data;
                state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = ST_WB;
            ST_WB: begin
                state_d = ST_FETCH;
                unique case (dec_cls)
                    CLS_ALU, CLS_MOV: begin
                        if (dec_dst) reg_b_d = wb_val;
                        else         reg_a_d = wb_val;
                        flag_z_d = (wb_val == '0);
                        pc_d     = pc_inc;
                    end
                    CLS_JMP: begin
                        pc_d = (!dec_jz || flag_z_q) ? dec_imm[ADDR_W-1:0] : pc_inc;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ROM address follows pc continuously, so it is already valid during FETCH.
    assign rom_addr = pc_q;
    assign alu_a    = reg_a_q;
    assign alu_b    = dec_bsel ? dec_imm : reg_b_q;
    assign alu_s    = dec_alu_s;
    assign reg_a    = reg_a_q;
    assign reg_b    = reg_b_q;
    assign flag_z   = flag_z_q;
    assign pc       = pc_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a ROM of
// one-cycle read latency; expected values are hand-computed per step.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_s;
    logic [7:0]  reg_a, reg_b, pc;
    logic        flag_z, busy, halted;

    logic [15:0] rom [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_out  (alu_out),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .flag_z   (flag_z),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    always_comb begin
        case (alu_s)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a ^ alu_b;
            3'b101:  alu_out = ~alu_a;
            3'b110:  alu_out = {alu_a[6:0], 1'b0};
            default: alu_out = {1'b0, alu_a[7:1]};
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    endtask

    initial begin
        fill_halt();
        rst   = 1'b1;
        start = 1'b0;
        step(2);
        check("rst_pc",     16'(pc),     16'h00);
        check("rst_reg_a",  16'(reg_a),  16'h00);
        check("rst_reg_b",  16'(reg_b),  16'h00);
        check("rst_busy",   16'(busy),   16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_alu_s",  16'(alu_s),  16'h0);
        check("rst_flag_z", 16'(flag_z), 16'h0);
        start = 1'b1;
        step(1);
        check("rst_beats_start", 16'(busy), 16'h0);
        rst   = 1'b0;
        start = 1'b0;

        // MOV A,#05; MOV B,#03; ADD A,B; HALT
        rom[0] = 16'h4005;
        rom[1] = 16'h4403;
        rom[2] = 16'h0000;
        rom[3] = 16'hC000;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("p1_busy_fetch", 16'(busy), 16'h1);
        step(4);
        check("p1_mov_a", 16'(reg_a), 16'h05);
        check("p1_pc1",   16'(pc),    16'h01);
        step(6);
        check("p1_exec_alu_a", 16'(alu_a), 16'h05);
        check("p1_exec_alu_b", 16'(alu_b), 16'h03);
        check("p1_exec_alu_s", 16'(alu_s), 16'h0);
        step(6);
        check("p1_reg_a",  16'(reg_a),  16'h08);
        check("p1_reg_b",  16'(reg_b),  16'h03);
        check("p1_flag_z", 16'(flag_z), 16'h0);
        check("p1_halted", 16'(halted), 16'h1);
        check("p1_busy",   16'(busy),   16'h0);
        check("p1_pc",     16'(pc),     16'h03);

        // MOV A,#03; SUB A,#03; JZ 10; @10: MOV B,#01; JZ 40 (not taken); HALT
        fill_halt();
        rom[8'h00] = 16'h4003;
        rom[8'h01] = 16'h0A03;
        rom[8'h02] = 16'h8110;
        rom[8'h10] = 16'h4401;
        rom[8'h11] = 16'h8140;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("p2_restart_pc",   16'(pc),    16'h00);
        check("p2_retain_reg_a", 16'(reg_a), 16'h08);
        step(6);
        check("p2_exec_alu_s", 16'(alu_s), 16'h1);
        check("p2_exec_alu_a", 16'(alu_a), 16'h03);
        check("p2_exec_alu_b", 16'(alu_b), 16'h03);
        step(6);
        check("p2_jz_pc",     16'(pc),     16'h10);
        check("p2_reg_a",     16'(reg_a),  16'h00);
        check("p2_flag_z",    16'(flag_z), 16'h1);
        step(4);
        check("p2_mov_b",     16'(reg_b),  16'h01);
        check("p2_flag_clr",  16'(flag_z), 16'h0);
        step(4);
        check("p2_jz_not_taken", 16'(pc),  16'h12);
        step(4);
        check("p2_halted",    16'(halted), 16'h1);
        check("p2_halt_pc",   16'(pc),     16'h12);

        // MOV A,#80; SHL A; JZ 00 -> shifted-out zero takes the jump back
        fill_halt();
        rom[0] = 16'h4080;
        rom[1] = 16'h3000;
        rom[2] = 16'h8100;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        check("p3_shl_reg_a", 16'(reg_a),  16'h00);
        check("p3_shl_flag",  16'(flag_z), 16'h1);
        step(4);
        check("p3_jz_pc",     16'(pc),     16'h00);
        check("p3_busy",      16'(busy),   16'h1);
        step(4);
        check("p3_loop_reg_a", 16'(reg_a),  16'h80);
        check("p3_loop_flag",  16'(flag_z), 16'h0);
        check("p3_loop_pc",    16'(pc),     16'h01);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // JMP FE; NOPs at FE/FF -> pc FE, FF, 00 with start held while busy
        fill_halt();
        rom[8'h00] = 16'h80FE;
        rom[8'hFE] = 16'h0200;
        rom[8'hFF] = 16'h0200;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("p4_pc_fe", 16'(pc), 16'hFE);
        start = 1'b1;
        step(4);
        start = 1'b0;
        check("p4_pc_ff",   16'(pc),     16'hFF);
        check("p4_busy_ff", 16'(busy),   16'h1);
        check("p4_nop_z",   16'(flag_z), 16'h1);
        step(4);
        check("p4_pc_wrap", 16'(pc),     16'h00);
        check("p4_busy_00", 16'(busy),   16'h1);
        step(4);
        check("p4_pc_loop", 16'(pc),     16'hFE);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // ADD A,#7F interrupted by rst during EXEC, then during WB
        fill_halt();
        rom[0] = 16'h027F;
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(1);
        check("p5_exec_alu_b", 16'(alu_b), 16'h7F);
        check("p5_exec_busy",  16'(busy),  16'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("p5_rst_busy",  16'(busy),  16'h0);
        check("p5_rst_alu_b", 16'(alu_b), 16'h00);
        check("p5_rst_reg_a", 16'(reg_a), 16'h00);
        check("p5_rst_pc",    16'(pc),    16'h00);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("p5_wb_rst_reg_a", 16'(reg_a),  16'h00);
        check("p5_wb_rst_pc",    16'(pc),     16'h00);
        check("p5_wb_rst_busy",  16'(busy),   16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
